// File: rtl/rram_arbiter_pkg.sv
// Shared types and defaults for the rram arbiter slice.
package rram_pkg;

    localparam int unsigned NPORT     = 2;
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_AW    = 11;
    localparam int unsigned DEF_DEPTH = 2048;

    typedef enum logic {
        S_CLR = 1'b0,
        S_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/rram_arbiter_if.sv
// Two-port request/response bus between requesters and the rram arbiter.
interface rram_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 11
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [AW-1:0]    req_adr0;
    logic [AW-1:0]    req_adr1;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [1:0]       rsp_valid;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_adr0, req_adr1, req_data0, req_data1,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_adr0, req_adr1, req_data0, req_data1,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; one-hot grant, pointer remembers last winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    // 1 = port 1 won last, so port 0 takes the first contention after reset
    logic r_last;

    // Grant selection: lone requester wins, contention goes to the port that did not win last
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            unique case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    // Pointer tracks the most recent winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end
endmodule

// File: rtl/rram_arbiter.sv
// Shares a single-port rram between two requesters and owns the array clear engine.
module rram_arbiter
    import rram_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    rram_arbiter_if.slave    bus,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             m_rw_n,
    output logic [AW-1:0]    m_adr,
    output logic [WIDTH-1:0] m_data,
    input  logic [WIDTH-1:0] m_rdata
);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [NPORT-1:0] r_rsp_valid;
    logic             w_en;
    logic             w_cnt_last;
    logic [NPORT-1:0] w_gnt;

    assign w_cnt_last = (r_cnt == CNT_LAST);
    // clr_start pre-empts arbitration in the cycle it is seen
    assign w_en       = (r_state == S_RUN) && !clr_start;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .i_req (bus.req_valid),
        .o_gnt (w_gnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_CLR:   if (w_cnt_last) w_state_nxt = S_RUN;
            S_RUN:   if (clr_start)  w_state_nxt = S_CLR;
            default: w_state_nxt = S_CLR;
        endcase
    end

    // Clear address counter: advances only while clearing, parked at 0 otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_CLR && !w_cnt_last) begin
            r_cnt <= r_cnt + AW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Output logic: clear writes, granted access, or a harmless idle read
    always_comb begin
        clr_busy = 1'b0;
        clr_done = 1'b0;
        m_rw_n   = 1'b1;
        m_adr    = '0;
        m_data   = '0;
        unique case (r_state)
            S_CLR: begin
                clr_busy = 1'b1;
                clr_done = w_cnt_last;
                m_rw_n   = 1'b0;
                m_adr    = r_cnt;
            end
            S_RUN: begin
                if (w_gnt[0]) begin
                    m_rw_n = !bus.req_we[0];
                    m_adr  = bus.req_adr0;
                    if (bus.req_we[0]) m_data = bus.req_data0;
                end else if (w_gnt[1]) begin
                    m_rw_n = !bus.req_we[1];
                    m_adr  = bus.req_adr1;
                    if (bus.req_we[1]) m_data = bus.req_data1;
                end
            end
            default: ;
        endcase
    end

    // Response tag: one-hot port of the read granted last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= w_gnt & ~bus.req_we;
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = m_rdata;
endmodule

// File: tb/tb_rram_arbiter.sv
// Directed self-checking bench for rram_arbiter with a behavioural rram model.
module tb_rram_arbiter;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 11;
    localparam int unsigned DEPTH = 2048;

    logic             clk;
    logic             rst_n;
    logic             clr_start;
    logic             clr_busy;
    logic             clr_done;
    logic             m_rw_n;
    logic [AW-1:0]    m_adr;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_rdata;

    int unsigned n_chk;
    int unsigned n_fail;

    rram_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    rram_arbiter #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .m_rw_n    (m_rw_n),
        .m_adr     (m_adr),
        .m_data    (m_data),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read single-port memory; starts non-zero so the clear is visible
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'hEE;
        m_rdata = '0;
    end
    always @(posedge clk) begin
        if (!rst_n)       m_rdata <= '0;
        else if (m_rw_n)  m_rdata <= mem[m_adr];
        else              mem[m_adr] <= m_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of requester stimulus at the falling edge, settle combinational outputs
    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                         input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1,
                         input logic cs);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_adr0  = a0;
        bus.req_data0 = d0;
        bus.req_adr1  = a1;
        bus.req_data1 = d1;
        clr_start     = cs;
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
        chk({tag, "_rsp"},   32'(bus.rsp_valid), 32'h0);
        chk({tag, "_busy"},  32'(clr_busy),      32'h1);
        chk({tag, "_done"},  32'(clr_done),      32'h0);
        chk({tag, "_rwn"},   32'(m_rw_n),        32'h0);
        chk({tag, "_adr"},   32'(m_adr),         32'h0);
        chk({tag, "_data"},  32'(m_data),        32'h0);
    endtask

    // Caller is positioned at clear cycle 0; walks all DEPTH clear cycles
    task automatic run_clear(input string tag);
        int unsigned bad;
        int unsigned done_at;
        bad     = 0;
        done_at = 32'hFFFF_FFFF;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (clr_busy !== 1'b1 || bus.req_ready !== 2'b00 || m_rw_n !== 1'b0 ||
                m_adr !== AW'(k) || m_data !== '0) bad++;
            if (clr_done === 1'b1) begin
                if (done_at == 32'hFFFF_FFFF) done_at = k;
                else bad++;
            end
            @(negedge clk);
            #1;
        end
        chk({tag, "_seq"},     bad,              0);
        chk({tag, "_done_at"}, done_at,          DEPTH - 1);
        chk({tag, "_busy_end"}, 32'(clr_busy),   32'h0);
    endtask

    initial begin
        int unsigned bad;
        int unsigned npulse;
        logic [AW-1:0] rb_adr [5];

        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clr_start     = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b00;
        bus.req_adr0  = '0;
        bus.req_adr1  = '0;
        bus.req_data0 = '0;
        bus.req_data1 = '0;

        // Reset values, with both requests asserted
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("rst");
        bus.req_valid = 2'b00;

        // Power-on clear
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_clear("clr_por");

        // Read of the last word after clear
        drive(2'b01, 2'b00, 11'h7FF, 8'h00, '0, '0, 1'b0);
        chk("rd7ff_ready", 32'(bus.req_ready), 32'h1);
        chk("rd7ff_rwn",   32'(m_rw_n),        32'h1);
        chk("rd7ff_adr",   32'(m_adr),         32'h7FF);
        idle();
        chk("rd7ff_rsp",   32'(bus.rsp_valid), 32'h1);
        chk("rd7ff_data",  32'(bus.rsp_data),  32'h0);
        chk("idle_adr",    32'(m_adr),         32'h0);
        chk("idle_rwn",    32'(m_rw_n),        32'h1);

        // Write then read same address back to back on port 0
        drive(2'b01, 2'b01, 11'h010, 8'hA5, '0, '0, 1'b0);
        chk("wr_ready", 32'(bus.req_ready), 32'h1);
        chk("wr_rwn",   32'(m_rw_n),        32'h0);
        chk("wr_adr",   32'(m_adr),         32'h010);
        chk("wr_data",  32'(m_data),        32'hA5);
        drive(2'b01, 2'b00, 11'h010, 8'h00, '0, '0, 1'b0);
        chk("raw_ready",  32'(bus.req_ready), 32'h1);
        chk("wr_no_rsp",  32'(bus.rsp_valid), 32'h0);
        idle();
        chk("raw_rsp",    32'(bus.rsp_valid), 32'h1);
        chk("raw_data",   32'(bus.rsp_data),  32'hA5);

        // Seed words for contention; p1 write leaves the pointer on port 1
        drive(2'b01, 2'b01, 11'h001, 8'h5A, '0, '0, 1'b0);
        drive(2'b10, 2'b10, '0, '0, 11'h002, 8'h3C, 1'b0);
        chk("p1wr_ready", 32'(bus.req_ready), 32'h2);
        chk("p1wr_data",  32'(m_data),        32'h3C);

        // Continuous contention: strict alternation starting with port 0
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 2'b00, 11'h001, '0, 11'h002, '0, 1'b0);
            chk($sformatf("cont%0d_ready", i), 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("cont%0d_adr", i),   32'(m_adr),         (i % 2 == 0) ? 32'h001 : 32'h002);
            if (i > 0) begin
                chk($sformatf("cont%0d_rsp", i),  32'(bus.rsp_valid), (i % 2 == 0) ? 32'h2 : 32'h1);
                chk($sformatf("cont%0d_rdat", i), 32'(bus.rsp_data),  (i % 2 == 0) ? 32'h3C : 32'h5A);
            end
        end
        idle();
        chk("cont_last_rsp",  32'(bus.rsp_valid), 32'h2);
        chk("cont_last_data", 32'(bus.rsp_data),  32'h3C);

        // Port 1 burst: 16 writes then 16 reads
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            drive(2'b10, 2'b10, '0, '0, AW'(k), WIDTH'(k), 1'b0);
            if (bus.req_ready !== 2'b10 || m_rw_n !== 1'b0 ||
                m_adr !== AW'(k) || m_data !== WIDTH'(k)) bad++;
        end
        chk("p1_wr_burst", bad, 0);
        bad    = 0;
        npulse = 0;
        for (int k = 0; k < 16; k++) begin
            drive(2'b10, 2'b00, '0, '0, AW'(k), '0, 1'b0);
            if (bus.req_ready !== 2'b10) bad++;
            if (k > 0) begin
                if (bus.rsp_valid === 2'b10) npulse++;
                if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== WIDTH'(k - 1)) bad++;
            end
        end
        idle();
        if (bus.rsp_valid === 2'b10) npulse++;
        chk("p1_rd_last",   32'(bus.rsp_data), 32'h0F);
        chk("p1_rd_burst",  bad,    0);
        chk("p1_rd_pulses", npulse, 16);

        // clr_start during contention: prior read still answers, no grant this cycle
        drive(2'b11, 2'b00, 11'h010, '0, 11'h005, '0, 1'b0);
        chk("pre_clr_ready", 32'(bus.req_ready), 32'h1);
        drive(2'b11, 2'b00, 11'h010, '0, 11'h005, '0, 1'b1);
        chk("clr_st_ready", 32'(bus.req_ready), 32'h0);
        chk("clr_st_rsp",   32'(bus.rsp_valid), 32'h1);
        chk("clr_st_data",  32'(bus.rsp_data),  32'hA5);
        idle();
        run_clear("clr_cmd");

        // Everything written earlier reads back zero
        rb_adr = '{11'h001, 11'h002, 11'h010, 11'h000, 11'h00F};
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            drive(2'b01, 2'b00, rb_adr[i], '0, '0, '0, 1'b0);
            idle();
            if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== '0) bad++;
        end
        chk("post_clr_zero", bad, 0);

        // Reset with a read in flight: the response is dropped
        drive(2'b01, 2'b00, 11'h7FF, '0, '0, '0, 1'b0);
        chk("inflight_ready", 32'(bus.req_ready), 32'h1);
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        check_reset_vals("rst_rd");
        @(negedge clk);
        #1;
        chk("rst_rd_no_rsp", 32'(bus.rsp_valid), 32'h0);

        // Reset at clear cycle 1000, then a full clear from address 0
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        repeat (1000) @(negedge clk);
        #1;
        chk("mid_clr_adr", 32'(m_adr), 32'd1000);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_clr");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_clear("clr_restart");

        drive(2'b10, 2'b00, '0, '0, 11'h7FF, '0, 1'b0);
        idle();
        chk("final_rsp",  32'(bus.rsp_valid), 32'h2);
        chk("final_data", 32'(bus.rsp_data),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rram_arbiter.md
# rram_arbiter

Controller that sequences and shares the single-port `rram` storage array between two independent requesters. It arbitrates per-cycle access with round-robin fairness and returns read data with fixed latency. It also owns a sequential clear engine that zeroes every word after reset or on command. Sits directly in front of `rram`, driving its `rw_n`/`i_adr`/`i_data` and consuming its `o_data`.

## Interface
- `WIDTH`, 8, data word width (must match `rram`)
- `AW`, 11, address width
- `DEPTH`, 2048, number of words cleared (`DEPTH <= 2**AW`)

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — reset, asynchronous assert, active-low
- `req_valid` in 2 — per-port request valid (bit 0 = port 0)
- `req_ready` out 2 — per-port accept; transfer when valid && ready
- `req_we` in 2 — per-port 1 = write, 0 = read
- `req_adr0`, `req_adr1` in AW — per-port address
- `req_data0`, `req_data1` in WIDTH — per-port write data
- `rsp_valid` out 2 — per-port read-data strobe, one-cycle pulse
- `rsp_data` out WIDTH — read data, shared, qualified by `rsp_valid`
- `clr_start` in 1 — pulse: start full-array clear
- `clr_busy` out 1 — high while clear in progress
- `clr_done` out 1 — one-cycle pulse on final clear write
- `m_rw_n` out 1 — to `rram.rw_n` (1 = read, 0 = write)
- `m_adr` out AW — to `rram.i_adr`
- `m_data` out WIDTH — to `rram.i_data`
- `m_rdata` in WIDTH — from `rram.o_data`

## Operation
- FSM states: `S_CLR`, `S_RUN`. Reset state `S_CLR`, clear counter = 0.
- `S_CLR`: each cycle drive `m_rw_n=0`, `m_adr=cnt`, `m_data=0`; cnt++. On cnt == DEPTH-1: pulse `clr_done`, go to `S_RUN` next cycle. `req_ready=0`. `clr_start` ignored.
- `S_RUN`: at most one grant per cycle.
  - Only one port valid: grant it.
  - Both valid: grant port ≠ `last`. `last` updates on every grant; reset value 1, so port 0 wins the first contention.
  - `req_ready[i]` = grant[i]; combinational from both `req_valid`. Requesters must not make valid depend on ready.
  - Granted write: `m_rw_n=0`, `m_adr`/`m_data` from port; no response.
  - Granted read: `m_rw_n=1`, `m_adr` from port; `rsp_valid[i]` pulses the following cycle.
  - No grant: `m_rw_n=1`, `m_adr=0`, `m_data=0` (idle read, harmless).
- `clr_start` in `S_RUN` has priority: no grant that cycle, enter `S_CLR` with cnt=0. A read granted the previous cycle still returns its response.
- Held request (valid without ready) must keep address/data/we stable. The arbiter does not check this.

## Timing
- Reset values: `req_ready=00`, `rsp_valid=00`, `clr_busy=1`, `clr_done=0`, `m_rw_n=0`, `m_adr=0`, `m_data=0`. Reset state is `S_CLR` at cnt 0. `rram`'s own reset dominates while `rst_n` is low.
- Clear takes exactly DEPTH cycles from reset release or from the cycle after `clr_start`. `clr_busy` drops the cycle after `clr_done`.
- Read latency: accept in cycle N, `rsp_valid` high in cycle N+1 with `rsp_data = m_rdata` (passthrough). No backpressure on responses.
- Throughput: one access per cycle. Under continuous contention, ports alternate strictly.
- Write then read to the same address in consecutive cycles returns the new data.
- Reset asserted mid-clear or mid-read: all state discarded. A pending `rsp_valid` is not issued. Clear restarts from address 0.
- `rsp_valid` is registered. Grant-path outputs (`req_ready`, `m_*`) are combinational from state and inputs.

## Structure
- Package `rram_pkg`: `AW`, `DEPTH` defaults; state enum `{S_CLR, S_RUN}`; `NPORT=2` constant.
- Sub-module `rr_arb2`: 2-requester round-robin with `last` pointer and enable input. Outputs a one-hot grant.
- Top holds the FSM, clear counter, response-tag register (valid + port id), and the `m_*` mux.

## Test plan
- Reset release, no requests → `clr_busy` high 2048 cycles, `clr_done` at cycle 2047, `req_ready` stays 00 throughout. A subsequent read of address 0x7FF returns 0.
- Port 0 writes 0xA5 @0x010, next cycle port 0 reads 0x010 → `rsp_valid=01` one cycle after the read accept, `rsp_data=0xA5`.
- Both ports valid reads for 6 cycles (p0 @0x001, p1 @0x002) → grants 0,1,0,1,0,1; `rsp_valid` alternates 01/10 with the correct data.
- `clr_start` while both ports valid → `req_ready=00` that cycle; a read accepted the prior cycle still responds; all previously written words read 0 after `clr_done`.
- Assert `rst_n` low at clear cycle 1000 → all outputs at reset values; after release the clear runs a full 2048 cycles from address 0.
- Port 1 only, back-to-back writes 0x00..0x0F to addresses 0..15, then reads → 16 consecutive `rsp_valid=10` pulses, data matching.
